// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that grants one requester at a time a
// burst of up to max_burst beats into a single downstream FIFO write port.
// Beats pass straight through combinationally (no added latency); the grant
// itself is held in registers and re-arbitrated in one IDLE cycle per grant.
module fifo_wr_arbiter #(
  parameter int data_width = 32,
  parameter int num_req    = 4,
  parameter int max_burst  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [num_req-1:0]               req_valid_i,
  input  logic [num_req*data_width-1:0]    req_data_i,
  output logic [num_req-1:0]               req_ready_o,
  input  logic                             fifo_full_i,
  output logic                             fifo_cs_o,
  output logic                             fifo_wr_en_o,
  output logic [data_width-1:0]            fifo_data_in_o,
  output logic                             grant_valid_o,
  output logic [$clog2(num_req)-1:0]       grant_id_o
);

  localparam int IDW = $clog2(num_req);
  localparam int CW  = $clog2(max_burst) + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q;
  logic [IDW-1:0]  grant_id_q;
  logic [IDW-1:0]  last_grant_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            grant_valid_q;

  logic [IDW-1:0]  rr_winner;
  logic            rr_found;
  int              rr_idx;
  logic            holder_valid;
  logic [data_width-1:0] holder_data;
  logic            beat;
  logic            last_beat;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = 0;
    for (int k = 1; k <= num_req; k++) begin
      rr_idx = int'(last_grant_q) + k;
      if (rr_idx >= num_req) rr_idx = rr_idx - num_req;
      if (!rr_found && req_valid_i[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = IDW'(rr_idx);
      end
    end
  end

  // Grant holder's view and beat qualification; fifo_full always vetoes a beat.
  always_comb begin
    holder_valid = req_valid_i[grant_id_q];
    holder_data  = req_data_i[int'(grant_id_q)*data_width +: data_width];
    beat         = grant_valid_q && holder_valid && !fifo_full_i;
    last_beat    = (beat_cnt_q == CW'(max_burst - 1));
  end

  // Output decode: only the holder sees ready; data is zero outside a grant.
  always_comb begin
    for (int i = 0; i < num_req; i++)
      req_ready_o[i] = grant_valid_q && !fifo_full_i && (grant_id_q == IDW'(i));
    fifo_wr_en_o   = beat;
    fifo_cs_o      = grant_valid_q;
    fifo_data_in_o = grant_valid_q ? holder_data : '0;
    grant_valid_o  = grant_valid_q;
    grant_id_o     = grant_id_q;
  end

  // Two-state grant FSM; reset restarts arbitration with requester 0 first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= IDW'(num_req - 1);
      beat_cnt_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rr_found) begin
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
            grant_id_q    <= rr_winner;
            last_grant_q  <= rr_winner;
            beat_cnt_q    <= '0;
          end
        end
        GRANT: begin
          if (!holder_valid) begin
            // Holder released: forfeit the rest of the burst.
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
          end else if (beat) begin
            if (last_beat) begin
              state_q       <= IDLE;
              grant_valid_q <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter data_width, default 32, width of each requester's write data and of the FIFO write data.
REQ-002 Parameter num_req, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter max_burst, default 4, maximum beats per grant; legal range 1..256.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  num_req  bit i high: requester i offers a beat.
REQ-007 req_data  input  num_req*data_width  requester i data in bits [i*data_width +: data_width].
REQ-008 req_ready  output  num_req  bit i high: requester i's beat is accepted this cycle.
REQ-009 fifo_full  input  1  full flag from the downstream FIFO.
REQ-010 fifo_cs  output  1  chip select to the FIFO.
REQ-011 fifo_wr_en  output  1  write enable to the FIFO.
REQ-012 fifo_data_in  output  data_width  write data to the FIFO.
REQ-013 grant_valid  output  1  high while a requester holds the grant.
REQ-014 grant_id  output  $clog2(num_req)  index of the current grant holder; meaningful only while grant_valid is high.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE (arbitrate) and GRANT (transfer).
- IDLE: grant_valid=0, req_ready=0, fifo_wr_en=0.
- IDLE -> GRANT when any req_valid bit is high.
- IDLE stays IDLE otherwise.
REQ-016 Arbitration in IDLE SHALL be round-robin.
- Search starts at index last_grant+1, modulo num_req, and wraps.
- The first requester with req_valid high is chosen.
- On the IDLE->GRANT edge, grant_id and last_grant are both registered to the winner.
REQ-017 In GRANT, req_ready[grant_id] SHALL equal !fifo_full (combinational); all other req_ready bits SHALL be 0.
REQ-018 A beat SHALL occur in GRANT when req_valid[grant_id] && !fifo_full.
- fifo_wr_en=1 and fifo_cs=1 in the same cycle.
- fifo_data_in = req_data slice of grant_id in the same cycle (zero added latency).
REQ-019 When no beat occurs:
- fifo_wr_en SHALL be 0.
- fifo_cs SHALL equal grant_valid.
- fifo_data_in SHALL hold the grant_id slice.
REQ-020 beat_cnt SHALL be $clog2(max_burst)+1 bits wide.
- Cleared on IDLE->GRANT.
- Incremented on each beat.
- Never wraps within a grant.
REQ-021 GRANT -> IDLE SHALL occur at the end of the cycle in which either:
- a beat occurs with beat_cnt==max_burst-1, or
- req_valid[grant_id] is 0 (requester released).
REQ-022 GRANT SHALL remain GRANT while req_valid[grant_id]=1 and fifo_full=1 (stall).
- No beat is counted.
- No timeout applies.
REQ-023 Every grant SHALL be followed by exactly one IDLE (arbitration) cycle.
- Minimum turnaround: 1 cycle between the last beat of one grant and the first beat of the next.
REQ-024 A requester dropping req_valid mid-burst SHALL forfeit the grant.
- Its re-assertion competes in round-robin order from the updated last_grant.
REQ-025 Changes to req_valid bits of non-granted requesters SHALL have no effect during GRANT.
REQ-026 fifo_full rising in the same cycle as a beat opportunity SHALL suppress that beat.
- Data SHALL never be written while fifo_full=1.

Reset
REQ-027 When rst=1 at a clock edge, the following SHALL apply on the next cycle regardless of current state, including mid-burst:
- state=IDLE
- grant_id=0
- last_grant=num_req-1, so requester 0 has first priority
- beat_cnt=0
- grant_valid=0
- req_ready=0
- fifo_wr_en=0
- fifo_cs=0
- fifo_data_in=0
REQ-028 A burst interrupted by reset SHALL NOT resume; arbitration restarts from REQ-027 values.

Verification
REQ-029 After reset, req_valid=4'b1111 held, fifo_full=0 -> grants in order 0,1,2,3,0.
- 4 beats each.
- 1 idle cycle between grants.
- 16 writes in 20 cycles after the first grant.
REQ-030 Only req 2 valid continuously, fifo_full=0 -> bursts of 4 beats.
- grant_id=2 throughout.
- fifo_wr_en pattern 1111_0_1111_0.
REQ-031 req 1 granted, fifo_full=1 for 3 cycles after 2nd beat -> req_ready[1]=0 and fifo_wr_en=0 for those 3 cycles; beats 3 and 4 complete after release, then IDLE.
REQ-032 req 3 drops req_valid after 2 beats with req 0 valid -> GRANT->IDLE; next grant_id=0; beat_cnt restarts at 0.
REQ-033 rst asserted during beat 3 of a burst -> next cycle all outputs 0 and state IDLE; with req_valid=4'b1111 the first grant after reset is 0.
REQ-034 Payload check with data 32'hA0000000+beat per requester -> FIFO receives every accepted beat exactly once, in order per requester, with none lost or duplicated under random fifo_full.
